seq_divider_16: RTL and testbench

SEQ_DIVIDER_16 -- requirements
Module: seq_divider_16

---
 rtl/seq_divider_16.sv | 101 ++++++++++
 tb/tb_seq_divider_16.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero completes in one cycle with quotient all ones and remainder = dividend.
module seq_divider_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] rem_q, acc_q, dvs_q;
  logic [CW-1:0]    cnt;

  logic             accept, last, qbit;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_n, acc_n;

  // Next state plus one restoring step; acc_q holds dividend bits, then quotient bits.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    shifted = {rem_q, acc_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    qbit    = ~trial[WIDTH];
    rem_n   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    acc_n   = {acc_q[WIDTH-2:0], qbit};
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = (divisor == '0) ? DONE : BUSY;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      div0      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      dvs_q     <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n == BUSY);
      done  <= (state_n == DONE);
      if (accept) begin
        if (divisor == '0) begin
          quotient  <= '1;
          remainder <= dividend;
          div0      <= 1'b1;
          cnt       <= '0;
        end else begin
          acc_q <= dividend;
          dvs_q <= divisor;
          rem_q <= '0;
          cnt   <= CW'(WIDTH);
          div0  <= 1'b0;
        end
      end else if (state == BUSY) begin
        rem_q <= rem_n;
        acc_q <= acc_n;
        cnt   <= cnt - CW'(1);
        // Results only become visible on the final step, so outputs hold until then.
        if (last) begin
          quotient  <= acc_n;
          remainder <= rem_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_16.sv
// Directed and reference-model checks for seq_divider_16: latency, results,
// divide-by-zero, ignored start in BUSY, reset abort and back-to-back starts.
module tb_seq_divider_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div0;
  logic [15:0] quotient, remainder;

  int n_checks = 0;
  int n_err    = 0;

  seq_divider_16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; launches one division and checks latency and results.
  // poke>0 pulses a start with different operands in that BUSY cycle.
  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] eq, input logic [15:0] er, input logic ediv0,
                     input int elat, input int ebusy, input int poke, input bit chain);
    int n_busy;
    bit seen;
    n_busy = 0;
    seen   = 1'b0;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        chk("latency", 32'(n), 32'(elat));
        seen = 1'b1;
        break;
      end
      if (busy) n_busy++;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      if (n == poke) begin
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("busy_cycles", 32'(n_busy), 32'(ebusy));
      chk("busy_in_done", 32'(busy), 32'd0);
      chk("quotient", 32'(quotient), 32'(eq));
      chk("remainder", 32'(remainder), 32'(er));
      chk("div0", 32'(div0), 32'(ediv0));
      if (!chain) begin
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("hold_quotient", 32'(quotient), 32'(eq));
      end
    end
  endtask

  initial begin
    logic [15:0] ra, rb, eq, er;
    int done_cnt;
    rst_n = 1'b0;
    start = 1'b1;
    dividend = 16'd9;
    divisor  = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);

    // First edge with rst_n high accepts the start.
    rst_n = 1'b1;
    run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16, 0, 1'b0);

    run(16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0, 17, 16, 0, 1'b1);
    run(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17, 16, 0, 1'b0);

    run(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, 0, 0, 1'b0);

    run(16'd1000, 16'd9, 16'd111, 16'd1, 1'b0, 17, 16, 5, 1'b0);

    // Reset mid-division aborts it without a done pulse.
    start = 1'b1;
    dividend = 16'd200;
    divisor  = 16'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_div0", 32'(div0), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("abort_no_activity", 32'(done_cnt), 32'd0);
    run(16'd200, 16'd3, 16'd66, 16'd2, 1'b0, 17, 16, 0, 1'b0);

    run(16'd0, 16'd7, 16'd0, 16'd0, 1'b0, 17, 16, 0, 1'b0);
    run(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 17, 16, 0, 1'b0);
    run(16'hFFFE, 16'hFFFF, 16'd0, 16'hFFFE, 1'b0, 17, 16, 0, 1'b0);
    run(16'h8000, 16'h0003, 16'h2AAA, 16'd2, 1'b0, 17, 16, 0, 1'b0);

    // Random operands against a reference model, edges mixed in.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 6 == 1) rb = 16'd1;
      if (i % 6 == 2) ra = 16'd0;
      if (i % 6 == 3) ra = 16'hFFFF;
      if (i % 6 == 4) rb = 16'($urandom_range(1, 15));
      if (i % 8 == 5) rb = 16'd0;
      if (rb == 16'd0) begin
        eq = 16'hFFFF;
        er = ra;
        run(ra, rb, eq, er, 1'b1, 1, 0, 0, 1'b0);
      end else begin
        eq = ra / rb;
        er = ra % rb;
        run(ra, rb, eq, er, 1'b0, 17, 16, 0, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
